// File: rtl/r5p_ifu.sv
// Instruction fetch unit: word fetch into a circular prefetch FIFO, presenting aligned instructions to decode.
// Define R5P_IFU_RVC_EN to enable compressed (16-bit) instruction alignment; default build fetches whole words only.
module r5p_ifu #(
  parameter int unsigned    IAW   = 32,
  parameter int unsigned    DEPTH = 4,
  parameter logic [IAW-1:0] PC0   = '0
)(
  input  logic           clk,
  input  logic           rst,
  output logic           if_req,
  output logic [IAW-1:0] if_adr,
  input  logic [31:0]    if_rdt,
  input  logic           if_ack,
  input  logic           jmp_vld,
  input  logic [IAW-1:0] jmp_adr,
  output logic           id_vld,
  input  logic           id_rdy,
  output logic [IAW-1:0] id_pc,
  output logic [31:0]    id_ins
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic           run;
  logic [IAW-1:0] fadr;
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  cnt;
  logic           hof, hof_nxt;
  logic [IAW-3:0] mem_adr [DEPTH];
  logic [31:0]    mem_dat [DEPTH];
  logic           full, push, pop, wpop, avail;
  logic [31:0]    w0, w1, ins;

  assign full   = (cnt == CW'(DEPTH));
  assign if_req = run & ~full & ~jmp_vld;
  assign if_adr = fadr;
  assign push   = if_req & if_ack;
  assign pop    = id_vld & id_rdy & ~jmp_vld;
  assign w0     = mem_dat[rptr];
  assign w1     = mem_dat[rptr + AW'(1)];

`ifdef R5P_IFU_RVC_EN
  logic [15:0] hw;
  logic        is16;
  logic        unused_bits;
  assign unused_bits = ^{jmp_adr[0], w1[31:16]};

  // A 32-bit instruction starting in the high half straddles the head and the next word.
  always_comb begin
    hw      = hof ? w0[31:16] : w0[15:0];
    is16    = (hw[1:0] != 2'b11);
    ins     = {w1[15:0], w0[31:16]};
    avail   = (cnt >= CW'(2));
    wpop    = pop;
    hof_nxt = hof;
    if (is16) begin
      ins   = {16'h0000, hw};
      avail = (cnt != '0);
      wpop  = pop & hof;
      if (pop) hof_nxt = ~hof;
    end else if (!hof) begin
      ins   = w0;
      avail = (cnt != '0);
    end
    if (jmp_vld) hof_nxt = jmp_adr[1];
  end
`else
  logic unused_bits;
  assign unused_bits = ^{jmp_adr[1:0], w1};

  always_comb begin
    ins     = w0;
    avail   = (cnt != '0);
    wpop    = pop;
    hof_nxt = 1'b0;
  end
`endif

  assign id_vld = avail;
  assign id_ins = id_vld ? ins : 32'h0;
  assign id_pc  = id_vld ? {mem_adr[rptr], hof, 1'b0} : PC0;

  // Control state; a redirect overrides both fetch write and decode pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run  <= 1'b0;
      fadr <= PC0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      hof  <= 1'b0;
    end else begin
      run <= 1'b1;
      hof <= hof_nxt;
      if (jmp_vld) begin
        fadr <= {jmp_adr[IAW-1:2], 2'b00};
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push) begin
          fadr <= fadr + IAW'(4);
          wptr <= wptr + AW'(1);
        end
        if (wpop) rptr <= rptr + AW'(1);
        cnt <= cnt + CW'(push) - CW'(wpop);
      end
    end
  end

  // Buffer storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_adr[wptr] <= fadr[IAW-1:2];
      mem_dat[wptr] <= if_rdt;
    end
  end

endmodule

// File: tb/tb_r5p_ifu.sv
// Directed self-checking bench for r5p_ifu (DEPTH=4, PC0=0); RVC alignment cases run when R5P_IFU_RVC_EN is defined.
module tb_r5p_ifu;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_adr;
  logic [31:0] if_rdt;
  logic        if_ack;
  logic        jmp_vld;
  logic [31:0] jmp_adr;
  logic        id_vld;
  logic        id_rdy;
  logic [31:0] id_pc;
  logic [31:0] id_ins;
  logic        img;
  int          n_chk;
  int          n_pass;
  int          acc;

  r5p_ifu #(.IAW(32), .DEPTH(4), .PC0(32'h0)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_rdt(if_rdt), .if_ack(if_ack),
    .jmp_vld(jmp_vld), .jmp_adr(jmp_adr),
    .id_vld(id_vld), .id_rdy(id_rdy), .id_pc(id_pc), .id_ins(id_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: default word is a 32-bit encoding tagged with its address.
  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic im);
    if (!im) return 32'hA500_0003 | a;
    case (a)
      32'h0000_0000: return 32'h0001_4501;
      32'h0000_0004: return 32'h0000_0513;
      32'h0000_0100: return 32'h0513_0000;
      32'h0000_0104: return 32'h1234_0000;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  always_comb if_rdt = mem_rd(if_adr, img);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    id_rdy = 1'b1;
    tick();
    id_rdy = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_pass = 0; acc = 0;
    rst = 1'b0; if_ack = 1'b0; id_rdy = 1'b0; jmp_vld = 1'b0; jmp_adr = '0; img = 1'b0;
    #12;
    chk("rst_if_req", {31'b0, if_req}, 32'd0);
    chk("rst_if_adr", if_adr, 32'h0);
    chk("rst_id_vld", {31'b0, id_vld}, 32'd0);
    chk("rst_id_pc",  id_pc,  32'h0);
    chk("rst_id_ins", id_ins, 32'h0);

    // streaming after reset release
    if_ack = 1'b1; id_rdy = 1'b1; rst = 1'b1;
    #1;
    chk("run_delay", {31'b0, if_req}, 32'd0);
    tick();
    chk("req_rise", {31'b0, if_req}, 32'd1);
    chk("adr_0", if_adr, 32'h0);
    tick();
    chk("adr_4", if_adr, 32'h4);
    chk("pc_0", id_pc, 32'h0);
    chk("ins_0", id_ins, 32'hA500_0003);
    tick();
    chk("adr_8", if_adr, 32'h8);
    chk("pc_4", id_pc, 32'h4);
    tick();
    chk("pc_8", id_pc, 32'h8);

    // fill to DEPTH with decode stalled
    jmp_vld = 1'b1; jmp_adr = 32'h40; id_rdy = 1'b0;
    #1;
    chk("jmp_blocks_req", {31'b0, if_req}, 32'd0);
    @(posedge clk); #1;
    jmp_vld = 1'b0;
    #1;
    chk("req_after_jmp", {31'b0, if_req}, 32'd1);
    chk("adr_after_jmp", if_adr, 32'h40);
    chk("vld_after_jmp", {31'b0, id_vld}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (if_req && if_ack) acc++;
      tick();
    end
    chk("fill_accepted", acc, 32'd4);
    chk("full_req", {31'b0, if_req}, 32'd0);
    chk("full_pc", id_pc, 32'h40);
    chk("full_adr", if_adr, 32'h50);
    pop1();
    chk("pop_req", {31'b0, if_req}, 32'd1);
    chk("pop_pc", id_pc, 32'h44);

    // redirect with 3 words buffered, decode ready in the same cycle
    jmp_vld = 1'b1; jmp_adr = 32'h100; id_rdy = 1'b1; if_ack = 1'b1;
    tick();
    jmp_vld = 1'b0; id_rdy = 1'b0; if_ack = 1'b0;
    #1;
    chk("flush_vld", {31'b0, id_vld}, 32'd0);
    chk("jmp_adr", if_adr, 32'h100);
    chk("jmp_req", {31'b0, if_req}, 32'd1);
    tick();
    chk("hold_adr", if_adr, 32'h100);
    if_ack = 1'b1;
    tick();
    if_ack = 1'b0;
    #1;
    chk("jmp_vld1", {31'b0, id_vld}, 32'd1);
    chk("jmp_pc", id_pc, 32'h100);
    chk("jmp_ins", id_ins, 32'hA500_0103);
    tick();
    chk("stall_pc", id_pc, 32'h100);
    chk("stall_ins", id_ins, 32'hA500_0103);

`ifndef R5P_IFU_RVC_EN
    // halfword target bit has no effect without compressed support
    jmp_vld = 1'b1; jmp_adr = 32'h10A;
    tick();
    jmp_vld = 1'b0; if_ack = 1'b1;
    tick();
    if_ack = 1'b0;
    #1;
    chk("nohof_pc", id_pc, 32'h108);
    chk("nohof_ins", id_ins, 32'hA500_010B);
`endif

    // asynchronous reset with a full buffer
    if_ack = 1'b1; id_rdy = 1'b0;
    repeat (6) tick();
    chk("pre_rst_vld", {31'b0, id_vld}, 32'd1);
    chk("pre_rst_req", {31'b0, if_req}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_vld", {31'b0, id_vld}, 32'd0);
    chk("arst_req", {31'b0, if_req}, 32'd0);
    chk("arst_ins", id_ins, 32'h0);
    chk("arst_pc", id_pc, 32'h0);
    chk("arst_adr", if_adr, 32'h0);
    #2;
    rst = 1'b1; id_rdy = 1'b1;
    tick();
    tick();
    chk("rel_pc", id_pc, 32'h0);
    chk("rel_ins", id_ins, 32'hA500_0003);

`ifdef R5P_IFU_RVC_EN
    // compressed alignment
    img = 1'b1; if_ack = 1'b0; id_rdy = 1'b0;
    jmp_vld = 1'b1; jmp_adr = 32'h0;
    tick();
    jmp_vld = 1'b0; if_ack = 1'b1;
    tick();
    tick();
    if_ack = 1'b0;
    #1;
    chk("rvc_ins0", id_ins, 32'h0000_4501);
    chk("rvc_pc0", id_pc, 32'h0);
    pop1();
    chk("rvc_ins1", id_ins, 32'h0000_0001);
    chk("rvc_pc1", id_pc, 32'h2);
    pop1();
    chk("rvc_ins2", id_ins, 32'h0000_0513);
    chk("rvc_pc2", id_pc, 32'h4);

    jmp_vld = 1'b1; jmp_adr = 32'h102;
    tick();
    jmp_vld = 1'b0;
    #1;
    chk("span_vld0", {31'b0, id_vld}, 32'd0);
    if_ack = 1'b1;
    tick();
    if_ack = 1'b0;
    #1;
    chk("span_vld1", {31'b0, id_vld}, 32'd0);
    if_ack = 1'b1;
    tick();
    if_ack = 1'b0;
    #1;
    chk("span_vld2", {31'b0, id_vld}, 32'd1);
    chk("span_ins", id_ins, 32'h0000_0513);
    chk("span_pc", id_pc, 32'h102);
    pop1();
    chk("after_span_ins", id_ins, 32'h0000_1234);
    chk("after_span_pc", id_pc, 32'h106);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
